// File: rtl/wl_sram_arb.sv
// rtl/wl_sram_arb.sv - two-requester round-robin arbiter/sequencer for one single-port wl_sram
//
// Purpose:
//   Grants at most one requester command per cycle onto a single-port wl_sram.
//   The grant drives the RAM pins combinationally.
//   A tag pipe of LAT = 1+OREG stages carries each read's issuer id, so the
//   read response is routed back to the requester that issued it.
//
// Ports:
//   clk, rst_b                       clock, asynchronous active-low reset
//   reqN_vld/rdy/we/addr/wdata       requester N command handshake (N = 0, 1)
//   rspN_vld/data                    requester N read response pulse
//   ram_wea/en/addr/din, ram_dout    wl_sram pins (tie wl_sram regce=1)
//   stat_clr, stat_grant0/1, stat_confl
//                                    present only when WL_SRAM_ARB_STATS_EN is defined
//
// Optional feature macro: WL_SRAM_ARB_STATS_EN (grant and conflict counters).
module wl_sram_arb #(
  parameter int DW   = 8,
  parameter int AW   = 10,
  parameter int OREG = 0
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          req0_vld,
  output logic          req0_rdy,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          rsp0_vld,
  output logic [DW-1:0] rsp0_data,
  input  logic          req1_vld,
  output logic          req1_rdy,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp1_vld,
  output logic [DW-1:0] rsp1_data,
`ifdef WL_SRAM_ARB_STATS_EN
  input  logic          stat_clr,
  output logic [15:0]   stat_grant0,
  output logic [15:0]   stat_grant1,
  output logic [15:0]   stat_confl,
`endif
  output logic          ram_wea,
  output logic          ram_en,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int LAT = 1 + OREG;

  logic           r_ptr;
  logic [LAT-1:0] r_tag_vld;
  logic [LAT-1:0] r_tag_id;

  logic w_grant0;
  logic w_grant1;
  logic w_rd;
  logic w_rsp_vld;
  logic w_rsp_id;

  // Grant is masked by rst_b so the RAM sees no access while reset is held,
  // whatever the requesters are doing.
  always_comb begin
    w_grant0 = rst_b & req0_vld & (~req1_vld | ~r_ptr);
    w_grant1 = rst_b & req1_vld & (~req0_vld |  r_ptr);
  end

  assign req0_rdy = w_grant0;
  assign req1_rdy = w_grant1;

  always_comb begin
    ram_en   = w_grant0 | w_grant1;
    ram_wea  = (w_grant0 & req0_we) | (w_grant1 & req1_we);
    ram_addr = '0;
    ram_din  = '0;
    if (w_grant0) begin
      ram_addr = req0_addr;
      ram_din  = req0_wdata;
    end else if (w_grant1) begin
      ram_addr = req1_addr;
      ram_din  = req1_wdata;
    end
  end

  assign w_rd = (w_grant0 & ~req0_we) | (w_grant1 & ~req1_we);

  // Pointer flips to the other requester after every grant and holds when idle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_ptr <= 1'b0;
    end else if (w_grant0) begin
      r_ptr <= 1'b1;
    end else if (w_grant1) begin
      r_ptr <= 1'b0;
    end
  end

  // Tag pipe: stage 0 captures the read issued this cycle, the last stage
  // lines up with ram_dout. Reset clears it so in-flight reads are dropped.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld[0] <= w_rd;
      r_tag_id[0]  <= w_grant1;
      for (int i = 1; i < LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  assign w_rsp_vld = r_tag_vld[LAT-1];
  assign w_rsp_id  = r_tag_id[LAT-1];

  always_comb begin
    rsp0_vld  = w_rsp_vld & ~w_rsp_id;
    rsp1_vld  = w_rsp_vld &  w_rsp_id;
    rsp0_data = rsp0_vld ? ram_dout : '0;
    rsp1_data = rsp1_vld ? ram_dout : '0;
  end

`ifdef WL_SRAM_ARB_STATS_EN
  logic        w_confl;
  logic [15:0] r_grant0_cnt;
  logic [15:0] r_grant1_cnt;
  logic [15:0] r_confl_cnt;

  assign w_confl = req0_vld & req1_vld;

  // Saturating counters; a clear in the same cycle as an increment wins.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_grant0_cnt <= '0;
      r_grant1_cnt <= '0;
      r_confl_cnt  <= '0;
    end else if (stat_clr) begin
      r_grant0_cnt <= '0;
      r_grant1_cnt <= '0;
      r_confl_cnt  <= '0;
    end else begin
      if (w_grant0 && r_grant0_cnt != 16'hFFFF) r_grant0_cnt <= r_grant0_cnt + 16'd1;
      if (w_grant1 && r_grant1_cnt != 16'hFFFF) r_grant1_cnt <= r_grant1_cnt + 16'd1;
      if (w_confl  && r_confl_cnt  != 16'hFFFF) r_confl_cnt  <= r_confl_cnt  + 16'd1;
    end
  end

  assign stat_grant0 = r_grant0_cnt;
  assign stat_grant1 = r_grant1_cnt;
  assign stat_confl  = r_confl_cnt;
`endif

endmodule
